// File: rtl/fe_capture_formatter.sv
// Front-end capture formatter: turns the sniffed USB byte/status stream into
// timestamped DATA/STAT/TIME events, buffered in a small pending queue.
module fe_capture_formatter #(
    parameter int pTIMESTAMP_FULL_WIDTH  = 16,
    parameter int pTIMESTAMP_SHORT_WIDTH = 3,
    parameter int pQUEUE_DEPTH           = 4
) (
    input  logic                             fe_clk,
    input  logic                             reset_i,
    input  logic                             I_capture_enable,
    input  logic                             I_timestamps_disable,
    input  logic [7:0]                       I_data,
    input  logic                             I_data_valid,
    input  logic [4:0]                       I_stat,
    input  logic                             I_fifo_full,
    output logic [pTIMESTAMP_FULL_WIDTH-1:0] O_fe_capture_time,
    output logic [7:0]                       O_fe_capture_data,
    output logic [4:0]                       O_fe_capture_stat,
    output logic [1:0]                       O_fe_capture_cmd,
    output logic                             O_fe_capture_data_wr,
    output logic                             O_overflow
);

    localparam int TW    = pTIMESTAMP_FULL_WIDTH;
    localparam int SW    = pTIMESTAMP_SHORT_WIDTH;
    localparam int PTR_W = $clog2(pQUEUE_DEPTH);

    localparam logic [1:0] CMD_DATA = 2'd0;
    localparam logic [1:0] CMD_STAT = 2'd1;
    localparam logic [1:0] CMD_TIME = 2'd2;

    localparam logic [0:0] ST_EMIT = 1'b0;
    localparam logic [0:0] ST_PAIR = 1'b1;

    localparam logic [TW-1:0]    DELTA_MAX = {TW{1'b1}};
    localparam logic [TW-1:0]    DELTA_ONE = {{(TW-1){1'b0}}, 1'b1};
    localparam logic [TW-1:0]    SHORT_MAX = {{(TW-SW){1'b0}}, {SW{1'b1}}};
    localparam logic [PTR_W-1:0] PTR_ONE   = {{(PTR_W-1){1'b0}}, 1'b1};
    localparam logic [PTR_W:0]   CNT_ONE   = {{PTR_W{1'b0}}, 1'b1};
    localparam logic [PTR_W:0]   CNT_FULL  = (PTR_W+1)'(pQUEUE_DEPTH);

    logic            enable_d_r;
    logic [4:0]      last_stat_r;
    logic [TW-1:0]   delta_r;
    logic [0:0]      state_r;
    logic            overflow_r;

    logic [1:0]      q_kind_r  [pQUEUE_DEPTH];
    logic [7:0]      q_data_r  [pQUEUE_DEPTH];
    logic [4:0]      q_stat_r  [pQUEUE_DEPTH];
    logic [TW-1:0]   q_delta_r [pQUEUE_DEPTH];
    logic [PTR_W-1:0] wr_ptr_r;
    logic [PTR_W-1:0] rd_ptr_r;
    logic [PTR_W:0]   count_r;

    logic [TW-1:0]   time_r;
    logic [7:0]      data_r;
    logic [4:0]      stat_r;
    logic [1:0]      cmd_r;
    logic            wr_r;

    logic            rise_s, push_req_s, push_ok_s, drop_s, pop_s, empty_s, full_s;
    logic [1:0]      push_kind_s;
    logic [7:0]      push_data_s;
    logic [4:0]      push_stat_s;
    logic [TW-1:0]   push_delta_s;
    logic [1:0]      head_kind_s;
    logic [7:0]      head_data_s;
    logic [4:0]      head_stat_s;
    logic [TW-1:0]   head_delta_s;
    logic [0:0]      nxt_state_s;
    logic [TW-1:0]   nxt_time_s;
    logic [7:0]      nxt_data_s;
    logic [4:0]      nxt_stat_s;
    logic [1:0]      nxt_cmd_s;
    logic            nxt_wr_s;
    logic [TW-1:0]   nxt_delta_s;

    assign rise_s       = I_capture_enable & ~enable_d_r;
    assign empty_s      = (count_r == {(PTR_W+1){1'b0}});
    assign full_s       = (count_r == CNT_FULL);
    assign head_kind_s  = q_kind_r[rd_ptr_r];
    assign head_data_s  = q_data_r[rd_ptr_r];
    assign head_stat_s  = q_stat_r[rd_ptr_r];
    assign head_delta_s = q_delta_r[rd_ptr_r];
    assign push_ok_s    = push_req_s & (~full_s | pop_s);
    assign drop_s       = push_req_s & full_s & ~pop_s;

    // Event detection: at most one candidate queue entry per cycle.
    always_comb begin
        push_req_s   = 1'b0;
        push_kind_s  = CMD_DATA;
        push_data_s  = 8'h00;
        push_stat_s  = I_stat;
        push_delta_s = delta_r;
        if (rise_s) begin
            push_req_s   = 1'b1;
            push_kind_s  = CMD_STAT;
            push_delta_s = {TW{1'b0}};
        end else if (I_capture_enable) begin
            if (I_data_valid) begin
                push_req_s  = 1'b1;
                push_data_s = I_data;
            end else if (I_stat != last_stat_r) begin
                push_req_s  = 1'b1;
                push_kind_s = CMD_STAT;
            end else if ((delta_r == DELTA_MAX) && !I_timestamps_disable) begin
                push_req_s  = 1'b1;
                push_kind_s = CMD_TIME;
                push_stat_s = 5'd0;
            end else begin
                push_req_s = 1'b0;
            end
        end else begin
            push_req_s = 1'b0;
        end
    end

    // Delta counter next value; a dropped event leaves it running (saturating).
    always_comb begin
        nxt_delta_s = (delta_r == DELTA_MAX) ? DELTA_MAX : (delta_r + DELTA_ONE);
        if (!I_capture_enable) begin
            nxt_delta_s = {TW{1'b0}};
        end else if (rise_s) begin
            nxt_delta_s = DELTA_ONE;
        end else if (push_ok_s) begin
            nxt_delta_s = (push_kind_s == CMD_TIME) ? {TW{1'b0}} : DELTA_ONE;
        end else begin
            nxt_delta_s = (delta_r == DELTA_MAX) ? DELTA_MAX : (delta_r + DELTA_ONE);
        end
    end

    // Output FSM: a long delta is sent as a TIME command ahead of the event itself.
    always_comb begin
        pop_s       = 1'b0;
        nxt_wr_s    = 1'b0;
        nxt_state_s = state_r;
        nxt_time_s  = time_r;
        nxt_data_s  = data_r;
        nxt_stat_s  = stat_r;
        nxt_cmd_s   = cmd_r;
        case (state_r)
            ST_EMIT: begin
                if (!empty_s && !I_fifo_full) begin
                    if (head_kind_s == CMD_TIME) begin
                        pop_s = 1'b1;
                        if (!I_timestamps_disable) begin
                            nxt_wr_s   = 1'b1;
                            nxt_cmd_s  = CMD_TIME;
                            nxt_time_s = head_delta_s;
                            nxt_data_s = 8'h00;
                            nxt_stat_s = 5'd0;
                        end else begin
                            nxt_wr_s = 1'b0;
                        end
                    end else if (!I_timestamps_disable && (head_delta_s > SHORT_MAX)) begin
                        nxt_wr_s    = 1'b1;
                        nxt_cmd_s   = CMD_TIME;
                        nxt_time_s  = head_delta_s;
                        nxt_data_s  = 8'h00;
                        nxt_stat_s  = 5'd0;
                        nxt_state_s = ST_PAIR;
                    end else begin
                        pop_s      = 1'b1;
                        nxt_wr_s   = 1'b1;
                        nxt_cmd_s  = head_kind_s;
                        nxt_data_s = head_data_s;
                        nxt_stat_s = head_stat_s;
                        nxt_time_s = I_timestamps_disable ? {TW{1'b0}} :
                                     {{(TW-SW){1'b0}}, head_delta_s[SW-1:0]};
                    end
                end else begin
                    nxt_state_s = ST_EMIT;
                end
            end
            ST_PAIR: begin
                if (!empty_s && !I_fifo_full) begin
                    pop_s       = 1'b1;
                    nxt_wr_s    = 1'b1;
                    nxt_cmd_s   = head_kind_s;
                    nxt_data_s  = head_data_s;
                    nxt_stat_s  = head_stat_s;
                    nxt_time_s  = {TW{1'b0}};
                    nxt_state_s = ST_EMIT;
                end else if (empty_s) begin
                    nxt_state_s = ST_EMIT;
                end else begin
                    nxt_state_s = ST_PAIR;
                end
            end
            default: nxt_state_s = ST_EMIT;
        endcase
    end

    // State, queue and registered outputs.
    always_ff @(posedge fe_clk) begin
        if (reset_i) begin
            enable_d_r  <= 1'b0;
            last_stat_r <= 5'd0;
            delta_r     <= {TW{1'b0}};
            state_r     <= ST_EMIT;
            overflow_r  <= 1'b0;
            wr_ptr_r    <= {PTR_W{1'b0}};
            rd_ptr_r    <= {PTR_W{1'b0}};
            count_r     <= {(PTR_W+1){1'b0}};
            time_r      <= {TW{1'b0}};
            data_r      <= 8'h00;
            stat_r      <= 5'd0;
            cmd_r       <= CMD_DATA;
            wr_r        <= 1'b0;
            for (int i = 0; i < pQUEUE_DEPTH; i++) begin
                q_kind_r[i]  <= CMD_DATA;
                q_data_r[i]  <= 8'h00;
                q_stat_r[i]  <= 5'd0;
                q_delta_r[i] <= {TW{1'b0}};
            end
        end else begin
            enable_d_r <= I_capture_enable;
            if (I_capture_enable) begin
                last_stat_r <= I_stat;
            end
            delta_r <= nxt_delta_s;
            state_r <= nxt_state_s;
            if (drop_s) begin
                overflow_r <= 1'b1;
            end else if (rise_s) begin
                overflow_r <= 1'b0;
            end
            if (push_ok_s) begin
                q_kind_r[wr_ptr_r]  <= push_kind_s;
                q_data_r[wr_ptr_r]  <= push_data_s;
                q_stat_r[wr_ptr_r]  <= push_stat_s;
                q_delta_r[wr_ptr_r] <= push_delta_s;
                wr_ptr_r            <= wr_ptr_r + PTR_ONE;
            end
            if (pop_s) begin
                rd_ptr_r <= rd_ptr_r + PTR_ONE;
            end
            case ({push_ok_s, pop_s})
                2'b10:   count_r <= count_r + CNT_ONE;
                2'b01:   count_r <= count_r - CNT_ONE;
                default: count_r <= count_r;
            endcase
            time_r <= nxt_time_s;
            data_r <= nxt_data_s;
            stat_r <= nxt_stat_s;
            cmd_r  <= nxt_cmd_s;
            wr_r   <= nxt_wr_s;
        end
    end

    assign O_fe_capture_time    = time_r;
    assign O_fe_capture_data    = data_r;
    assign O_fe_capture_stat    = stat_r;
    assign O_fe_capture_cmd     = cmd_r;
    assign O_fe_capture_data_wr = wr_r;
    assign O_overflow           = overflow_r;

endmodule

// File: tb/tb_fe_capture_formatter.sv
// Directed bench for fe_capture_formatter: strobed events are recorded with
// their cycle number and compared against hand-computed expectations.
module tb_fe_capture_formatter;

    logic        fe_clk = 1'b0;
    logic        reset_i;
    logic        I_capture_enable;
    logic        I_timestamps_disable;
    logic [7:0]  I_data;
    logic        I_data_valid;
    logic [4:0]  I_stat;
    logic        I_fifo_full;
    logic [15:0] O_fe_capture_time;
    logic [7:0]  O_fe_capture_data;
    logic [4:0]  O_fe_capture_stat;
    logic [1:0]  O_fe_capture_cmd;
    logic        O_fe_capture_data_wr;
    logic        O_overflow;

    typedef struct {
        logic [1:0]  cmd;
        logic [15:0] tm;
        logic [7:0]  data;
        logic [4:0]  stat;
        int          cyc;
    } ev_t;

    ev_t cap_q[$];
    int  cyc = 0;
    int  n_cmp = 0;
    int  n_fail = 0;

    fe_capture_formatter dut (
        .fe_clk               (fe_clk),
        .reset_i              (reset_i),
        .I_capture_enable     (I_capture_enable),
        .I_timestamps_disable (I_timestamps_disable),
        .I_data               (I_data),
        .I_data_valid         (I_data_valid),
        .I_stat               (I_stat),
        .I_fifo_full          (I_fifo_full),
        .O_fe_capture_time    (O_fe_capture_time),
        .O_fe_capture_data    (O_fe_capture_data),
        .O_fe_capture_stat    (O_fe_capture_stat),
        .O_fe_capture_cmd     (O_fe_capture_cmd),
        .O_fe_capture_data_wr (O_fe_capture_data_wr),
        .O_overflow           (O_overflow)
    );

    always #5 fe_clk = ~fe_clk;

    always @(posedge fe_clk) cyc <= cyc + 1;

    // Record every strobed event with the index of the edge that registered it.
    always @(negedge fe_clk) begin
        ev_t e;
        if (O_fe_capture_data_wr === 1'b1) begin
            e.cmd  = O_fe_capture_cmd;
            e.tm   = O_fe_capture_time;
            e.data = O_fe_capture_data;
            e.stat = O_fe_capture_stat;
            e.cyc  = cyc;
            cap_q.push_back(e);
        end
    end

    task automatic tick(input int n);
        for (int i = 0; i < n; i++) begin
            @(posedge fe_clk);
            #1;
        end
    endtask

    task automatic test_reset;
        reset_i = 1'b1;
        tick(2);
        n_cmp++;
        if ({O_fe_capture_time, O_fe_capture_data, O_fe_capture_stat, O_fe_capture_cmd,
             O_fe_capture_data_wr, O_overflow} !== 33'd0) begin
            n_fail++;
            $display("FAIL reset_outputs got time=%h data=%h stat=%h cmd=%0d wr=%b ovf=%b want all 0",
                     O_fe_capture_time, O_fe_capture_data, O_fe_capture_stat, O_fe_capture_cmd,
                     O_fe_capture_data_wr, O_overflow);
        end
        reset_i = 1'b0;
        tick(3);
        n_cmp++;
        if (cap_q.size() !== 0) begin
            n_fail++;
            $display("FAIL idle_no_events got %0d events want 0", cap_q.size());
        end
    endtask

    task automatic test_stat_data;
        int r;
        cap_q.delete();
        I_stat = 5'h01;
        I_capture_enable = 1'b1;
        tick(1);
        r = cyc;
        tick(2);
        I_data = 8'hA5; I_stat = 5'h03; I_data_valid = 1'b1;
        tick(1);
        I_data_valid = 1'b0; I_data = 8'h00;
        tick(4);
        n_cmp++;
        if (cap_q.size() !== 2) begin
            n_fail++;
            $display("FAIL t1_count got %0d want 2", cap_q.size());
        end
        n_cmp++;
        if ({cap_q[0].cmd, cap_q[0].tm, cap_q[0].data, cap_q[0].stat} !== {2'd1, 16'd0, 8'h00, 5'h01}
            || cap_q[0].cyc != r + 1) begin
            n_fail++;
            $display("FAIL t1_stat got cmd=%0d time=%0d data=%h stat=%h cyc=%0d want 1/0/00/01 cyc=%0d",
                     cap_q[0].cmd, cap_q[0].tm, cap_q[0].data, cap_q[0].stat, cap_q[0].cyc, r + 1);
        end
        n_cmp++;
        if ({cap_q[1].cmd, cap_q[1].tm, cap_q[1].data, cap_q[1].stat} !== {2'd0, 16'd3, 8'hA5, 5'h03}
            || cap_q[1].cyc != r + 4) begin
            n_fail++;
            $display("FAIL t1_data got cmd=%0d time=%0d data=%h stat=%h cyc=%0d want 0/3/a5/03 cyc=%0d",
                     cap_q[1].cmd, cap_q[1].tm, cap_q[1].data, cap_q[1].stat, cap_q[1].cyc, r + 4);
        end
        I_capture_enable = 1'b0;
        tick(3);
    endtask

    task automatic test_time_pair;
        int r;
        cap_q.delete();
        I_stat = 5'h00;
        I_capture_enable = 1'b1;
        tick(1);
        r = cyc;
        tick(20);
        I_data = 8'h11; I_data_valid = 1'b1;
        tick(1);
        I_data_valid = 1'b0;
        tick(4);
        n_cmp++;
        if (cap_q.size() !== 3) begin
            n_fail++;
            $display("FAIL t2_count got %0d want 3", cap_q.size());
        end
        n_cmp++;
        if ({cap_q[1].cmd, cap_q[1].tm} !== {2'd2, 16'd21} || cap_q[1].cyc != r + 22) begin
            n_fail++;
            $display("FAIL t2_time got cmd=%0d time=%0d cyc=%0d want 2/21 cyc=%0d",
                     cap_q[1].cmd, cap_q[1].tm, cap_q[1].cyc, r + 22);
        end
        n_cmp++;
        if ({cap_q[2].cmd, cap_q[2].tm, cap_q[2].data, cap_q[2].stat} !== {2'd0, 16'd0, 8'h11, 5'h00}
            || cap_q[2].cyc != r + 23) begin
            n_fail++;
            $display("FAIL t2_data got cmd=%0d time=%0d data=%h cyc=%0d want 0/0/11 cyc=%0d",
                     cap_q[2].cmd, cap_q[2].tm, cap_q[2].data, cap_q[2].cyc, r + 23);
        end
        I_capture_enable = 1'b0;
        tick(3);
    endtask

    task automatic test_wrap;
        int r;
        cap_q.delete();
        I_stat = 5'h00;
        I_capture_enable = 1'b1;
        tick(1);
        r = cyc;
        tick(65535);
        tick(5);
        I_data = 8'h5C; I_data_valid = 1'b1;
        tick(1);
        I_data_valid = 1'b0;
        tick(4);
        n_cmp++;
        if (cap_q.size() !== 3) begin
            n_fail++;
            $display("FAIL t3_count got %0d want 3", cap_q.size());
        end
        n_cmp++;
        if ({cap_q[1].cmd, cap_q[1].tm} !== {2'd2, 16'hFFFF} || cap_q[1].cyc != r + 65536) begin
            n_fail++;
            $display("FAIL t3_time got cmd=%0d time=%h cyc=%0d want 2/ffff cyc=%0d",
                     cap_q[1].cmd, cap_q[1].tm, cap_q[1].cyc, r + 65536);
        end
        n_cmp++;
        if ({cap_q[2].cmd, cap_q[2].tm, cap_q[2].data} !== {2'd0, 16'd5, 8'h5C} || cap_q[2].cyc != r + 65542) begin
            n_fail++;
            $display("FAIL t3_data got cmd=%0d time=%0d data=%h cyc=%0d want 0/5/5c cyc=%0d",
                     cap_q[2].cmd, cap_q[2].tm, cap_q[2].data, cap_q[2].cyc, r + 65542);
        end
        I_capture_enable = 1'b0;
        tick(3);
    endtask

    task automatic test_overflow;
        int c0;
        logic [7:0] exp_data [4];
        logic [15:0] exp_tm [4];
        logic [1:0] exp_cmd [4];
        exp_cmd = '{2'd1, 2'd0, 2'd0, 2'd0};
        exp_data = '{8'h00, 8'h21, 8'h22, 8'h23};
        exp_tm = '{16'd0, 16'd1, 16'd1, 16'd1};
        cap_q.delete();
        I_fifo_full = 1'b1;
        I_stat = 5'h00;
        I_capture_enable = 1'b1;
        tick(1);
        for (int i = 0; i < 6; i++) begin
            I_data = 8'h21 + 8'(i); I_data_valid = 1'b1;
            tick(1);
        end
        I_data_valid = 1'b0;
        tick(3);
        n_cmp++;
        if (cap_q.size() !== 0 || O_fe_capture_data_wr !== 1'b0) begin
            n_fail++;
            $display("FAIL t4_stall got %0d events wr=%b want 0 events wr=0", cap_q.size(), O_fe_capture_data_wr);
        end
        n_cmp++;
        if (O_overflow !== 1'b1) begin
            n_fail++;
            $display("FAIL t4_ovf_set got %b want 1", O_overflow);
        end
        c0 = cyc;
        I_fifo_full = 1'b0;
        tick(6);
        n_cmp++;
        if (cap_q.size() !== 4) begin
            n_fail++;
            $display("FAIL t4_count got %0d want 4", cap_q.size());
        end
        for (int i = 0; i < 4; i++) begin
            n_cmp++;
            if ({cap_q[i].cmd, cap_q[i].tm, cap_q[i].data} !== {exp_cmd[i], exp_tm[i], exp_data[i]}
                || cap_q[i].cyc != c0 + 1 + i) begin
                n_fail++;
                $display("FAIL t4_drain[%0d] got cmd=%0d time=%0d data=%h cyc=%0d want %0d/%0d/%h cyc=%0d",
                         i, cap_q[i].cmd, cap_q[i].tm, cap_q[i].data, cap_q[i].cyc,
                         exp_cmd[i], exp_tm[i], exp_data[i], c0 + 1 + i);
            end
        end
        n_cmp++;
        if (O_overflow !== 1'b1) begin
            n_fail++;
            $display("FAIL t4_ovf_sticky got %b want 1", O_overflow);
        end
        I_capture_enable = 1'b0;
        tick(2);
        I_capture_enable = 1'b1;
        tick(1);
        n_cmp++;
        if (O_overflow !== 1'b0) begin
            n_fail++;
            $display("FAIL t4_ovf_clear got %b want 0", O_overflow);
        end
        tick(3);
        I_capture_enable = 1'b0;
        tick(3);
    endtask

    task automatic test_ts_disable;
        int r;
        cap_q.delete();
        I_timestamps_disable = 1'b1;
        I_stat = 5'h00;
        I_capture_enable = 1'b1;
        tick(1);
        r = cyc;
        tick(30);
        I_data = 8'h7E; I_data_valid = 1'b1;
        tick(1);
        I_data_valid = 1'b0;
        tick(4);
        n_cmp++;
        if (cap_q.size() !== 2) begin
            n_fail++;
            $display("FAIL t5_count got %0d want 2", cap_q.size());
        end
        n_cmp++;
        if ({cap_q[1].cmd, cap_q[1].tm, cap_q[1].data} !== {2'd0, 16'd0, 8'h7E} || cap_q[1].cyc != r + 32) begin
            n_fail++;
            $display("FAIL t5_data got cmd=%0d time=%0d data=%h cyc=%0d want 0/0/7e cyc=%0d",
                     cap_q[1].cmd, cap_q[1].tm, cap_q[1].data, cap_q[1].cyc, r + 32);
        end
        I_capture_enable = 1'b0;
        tick(3);
        I_timestamps_disable = 1'b0;
    endtask

    task automatic test_reset_pair;
        int r2;
        cap_q.delete();
        I_stat = 5'h02;
        I_capture_enable = 1'b1;
        tick(1);
        tick(20);
        I_data = 8'h11; I_data_valid = 1'b1;
        tick(1);
        I_data_valid = 1'b0;
        tick(1);
        n_cmp++;
        if ({O_fe_capture_data_wr, O_fe_capture_cmd} !== {1'b1, 2'd2}) begin
            n_fail++;
            $display("FAIL t6_in_pair got wr=%b cmd=%0d want 1/2", O_fe_capture_data_wr, O_fe_capture_cmd);
        end
        reset_i = 1'b1;
        tick(1);
        n_cmp++;
        if ({O_fe_capture_time, O_fe_capture_data, O_fe_capture_stat, O_fe_capture_cmd,
             O_fe_capture_data_wr, O_overflow} !== 33'd0) begin
            n_fail++;
            $display("FAIL t6_reset_outputs got time=%h data=%h stat=%h cmd=%0d wr=%b want all 0",
                     O_fe_capture_time, O_fe_capture_data, O_fe_capture_stat, O_fe_capture_cmd,
                     O_fe_capture_data_wr);
        end
        reset_i = 1'b0;
        I_stat = 5'h0A;
        tick(1);
        r2 = cyc;
        tick(4);
        n_cmp++;
        if (cap_q.size() !== 3) begin
            n_fail++;
            $display("FAIL t6_count got %0d want 3", cap_q.size());
        end
        n_cmp++;
        if ({cap_q[2].cmd, cap_q[2].tm, cap_q[2].data, cap_q[2].stat} !== {2'd1, 16'd0, 8'h00, 5'h0A}
            || cap_q[2].cyc != r2 + 1) begin
            n_fail++;
            $display("FAIL t6_fresh_stat got cmd=%0d time=%0d data=%h stat=%h cyc=%0d want 1/0/00/0a cyc=%0d",
                     cap_q[2].cmd, cap_q[2].tm, cap_q[2].data, cap_q[2].stat, cap_q[2].cyc, r2 + 1);
        end
        I_capture_enable = 1'b0;
        tick(3);
    endtask

    initial begin
        reset_i = 1'b1;
        I_capture_enable = 1'b0;
        I_timestamps_disable = 1'b0;
        I_data = 8'h00;
        I_data_valid = 1'b0;
        I_stat = 5'h00;
        I_fifo_full = 1'b0;
        test_reset();
        test_stat_data();
        test_time_pair();
        test_wrap();
        test_overflow();
        test_ts_disable();
        test_reset_pair();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
